regfile_write_arbiter: RTL and testbench

Shares the single register-file write port (RegWrite / write_id / write_data into the decode stage) between three writers: the pipeline writeback stage, the multi-cycle multiply/divide unit (MDU) and the debug/program-loader port. Writeback has absolute priority and is never back-pressured. MDU and debug results sit in one-entry buffers until a free write slot appears. A starvation FSM asks the pipeline for a writeback bubble when a buffered result has waited too long.

---
 rtl/regfile_write_arbiter.sv | 167 ++++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between writeback, the MDU and the debug port.
// Writeback always wins; MDU/debug results wait in one-entry buffers, and a starvation FSM requests a writeback bubble.
module regfile_write_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_reg_write,
    input  logic [4:0]  wb_write_id,
    input  logic [31:0] wb_write_data,
    input  logic        mdu_valid,
    output logic        mdu_ready,
    input  logic [4:0]  mdu_write_id,
    input  logic [31:0] mdu_write_data,
    input  logic        dbg_valid,
    output logic        dbg_ready,
    input  logic [4:0]  dbg_write_id,
    input  logic [31:0] dbg_write_data,
    output logic        RegWrite,
    output logic [4:0]  write_id,
    output logic [31:0] write_data,
    output logic        stall_req,
    output logic        pending_valid,
    output logic [4:0]  pending_id
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        STALL
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] starve_cnt;
    logic [CW-1:0] starve_cnt_nxt;

    logic          active;
    logic          mdu_full;
    logic [4:0]    mdu_id;
    logic [31:0]   mdu_data;
    logic          dbg_full;
    logic [4:0]    dbg_id;
    logic [31:0]   dbg_data;

    logic          wb_req;
    logic          mdu_grant;
    logic          dbg_grant;
    logic          buf_grant;
    logic          mdu_accept;
    logic          dbg_accept;
    logic          mdu_full_nxt;
    logic          dbg_full_nxt;
    logic          any_full;
    logic          any_full_nxt;

    // A writeback to x0 is no request at all, so a buffered result may take the slot.
    assign wb_req       = wb_reg_write && (wb_write_id != 5'd0);
    assign mdu_grant    = !wb_req && mdu_full;
    assign dbg_grant    = !wb_req && !mdu_full && dbg_full;
    assign buf_grant    = mdu_grant || dbg_grant;

    assign mdu_ready    = active && !mdu_full;
    assign dbg_ready    = active && !dbg_full;
    assign mdu_accept   = mdu_valid && mdu_ready;
    assign dbg_accept   = dbg_valid && dbg_ready;

    assign mdu_full_nxt = mdu_accept || (mdu_full && !mdu_grant);
    assign dbg_full_nxt = dbg_accept || (dbg_full && !dbg_grant);
    assign any_full     = mdu_full || dbg_full;
    assign any_full_nxt = mdu_full_nxt || dbg_full_nxt;

    assign pending_valid = mdu_full;
    assign pending_id    = mdu_full ? mdu_id : 5'd0;
    assign stall_req     = (state == STALL);

    always_ff @(posedge clk) begin
        if (!rst) begin
            active   <= 1'b0;
            mdu_full <= 1'b0;
            mdu_id   <= 5'd0;
            mdu_data <= 32'd0;
            dbg_full <= 1'b0;
            dbg_id   <= 5'd0;
            dbg_data <= 32'd0;
        end else begin
            active   <= 1'b1;
            mdu_full <= mdu_full_nxt;
            dbg_full <= dbg_full_nxt;
            if (mdu_accept) begin
                mdu_id   <= mdu_write_id;
                mdu_data <= mdu_write_data;
            end
            if (dbg_accept) begin
                dbg_id   <= dbg_write_id;
                dbg_data <= dbg_write_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            RegWrite   <= 1'b0;
            write_id   <= 5'd0;
            write_data <= 32'd0;
        end else if (wb_req) begin
            RegWrite   <= 1'b1;
            write_id   <= wb_write_id;
            write_data <= wb_write_data;
        end else if (mdu_grant) begin
            RegWrite   <= (mdu_id != 5'd0);
            write_id   <= mdu_id;
            write_data <= mdu_data;
        end else if (dbg_grant) begin
            RegWrite   <= (dbg_id != 5'd0);
            write_id   <= dbg_id;
            write_data <= dbg_data;
        end else begin
            RegWrite   <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            starve_cnt <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_cnt_nxt;
        end
    end

    // Counter saturates at the limit; any buffer grant restarts the starvation window.
    always_comb begin
        state_nxt      = state;
        starve_cnt_nxt = starve_cnt;
        if (buf_grant) begin
            starve_cnt_nxt = '0;
        end else if (any_full && (starve_cnt != STARVE_MAX)) begin
            starve_cnt_nxt = starve_cnt + 1'b1;
        end
        case (state)
            IDLE: begin
                if (any_full_nxt) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (buf_grant) begin
                    state_nxt = any_full_nxt ? WAIT : IDLE;
                end else if (any_full && (starve_cnt_nxt == STARVE_MAX)) begin
                    state_nxt = STALL;
                end
            end
            STALL: begin
                if (buf_grant) begin
                    state_nxt = any_full_nxt ? WAIT : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized and directed bench for regfile_write_arbiter against a cycle-level behavioural model.
module tb_regfile_write_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wb_reg_write = 1'b0;
    logic [4:0]  wb_write_id = 5'd0;
    logic [31:0] wb_write_data = 32'd0;
    logic        mdu_valid = 1'b0;
    logic        mdu_ready;
    logic [4:0]  mdu_write_id = 5'd0;
    logic [31:0] mdu_write_data = 32'd0;
    logic        dbg_valid = 1'b0;
    logic        dbg_ready;
    logic [4:0]  dbg_write_id = 5'd0;
    logic [31:0] dbg_write_data = 32'd0;
    logic        RegWrite;
    logic [4:0]  write_id;
    logic [31:0] write_data;
    logic        stall_req;
    logic        pending_valid;
    logic [4:0]  pending_id;

    int passed = 0;
    int total  = 0;

    // Model state: buffers, whether the block is out of reset, and denied cycles since the last buffer grant.
    logic        m_active = 1'b0;
    logic        m_full = 1'b0;
    logic [4:0]  m_id = 5'd0;
    logic [31:0] m_data = 32'd0;
    logic        d_full = 1'b0;
    logic [4:0]  d_id = 5'd0;
    logic [31:0] d_data = 32'd0;
    int          denied = 0;
    logic        exp_rw = 1'b0;
    logic [4:0]  exp_id = 5'd0;
    logic [31:0] exp_data = 32'd0;
    logic        exp_bus_check = 1'b0;

    regfile_write_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk),
        .rst(rst),
        .wb_reg_write(wb_reg_write),
        .wb_write_id(wb_write_id),
        .wb_write_data(wb_write_data),
        .mdu_valid(mdu_valid),
        .mdu_ready(mdu_ready),
        .mdu_write_id(mdu_write_id),
        .mdu_write_data(mdu_write_data),
        .dbg_valid(dbg_valid),
        .dbg_ready(dbg_ready),
        .dbg_write_id(dbg_write_id),
        .dbg_write_data(dbg_write_data),
        .RegWrite(RegWrite),
        .write_id(write_id),
        .write_data(write_data),
        .stall_req(stall_req),
        .pending_valid(pending_valid),
        .pending_id(pending_id)
    );

    always #5 clk = ~clk;

    task automatic compareValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic modelStep();
        logic wb_wins;
        logic granted;
        logic any_full_before;
        logic mdu_rdy_before;
        logic dbg_rdy_before;
        if (!rst) begin
            m_active = 1'b0;
            m_full = 1'b0;
            m_id = 5'd0;
            d_full = 1'b0;
            d_id = 5'd0;
            denied = 0;
            exp_rw = 1'b0;
            exp_id = 5'd0;
            exp_data = 32'd0;
            exp_bus_check = 1'b1;
        end else begin
            wb_wins = wb_reg_write && (wb_write_id != 5'd0);
            any_full_before = m_full || d_full;
            mdu_rdy_before = m_active && !m_full;
            dbg_rdy_before = m_active && !d_full;
            granted = 1'b0;
            if (wb_wins) begin
                exp_rw = 1'b1;
                exp_id = wb_write_id;
                exp_data = wb_write_data;
            end else if (m_full) begin
                exp_rw = (m_id != 5'd0);
                exp_id = m_id;
                exp_data = m_data;
                m_full = 1'b0;
                granted = 1'b1;
            end else if (d_full) begin
                exp_rw = (d_id != 5'd0);
                exp_id = d_id;
                exp_data = d_data;
                d_full = 1'b0;
                granted = 1'b1;
            end else begin
                exp_rw = 1'b0;
            end
            exp_bus_check = exp_rw;
            if (granted) denied = 0;
            else if (any_full_before) denied++;
            if (mdu_valid && mdu_rdy_before) begin
                m_full = 1'b1;
                m_id = mdu_write_id;
                m_data = mdu_write_data;
            end
            if (dbg_valid && dbg_rdy_before) begin
                d_full = 1'b1;
                d_id = dbg_write_id;
                d_data = dbg_write_data;
            end
            m_active = 1'b1;
        end
    endtask

    task automatic checkOutput();
        compareValue("RegWrite", {31'd0, RegWrite}, {31'd0, exp_rw});
        if (exp_bus_check) begin
            compareValue("write_id", {27'd0, write_id}, {27'd0, exp_id});
            compareValue("write_data", write_data, exp_data);
        end
        compareValue("stall_req", {31'd0, stall_req},
                     {31'd0, (denied >= LIMIT) && (m_full || d_full)});
        compareValue("pending_valid", {31'd0, pending_valid}, {31'd0, m_full});
        compareValue("pending_id", {27'd0, pending_id}, {27'd0, m_full ? m_id : 5'd0});
        compareValue("mdu_ready", {31'd0, mdu_ready}, {31'd0, m_active && !m_full});
        compareValue("dbg_ready", {31'd0, dbg_ready}, {31'd0, m_active && !d_full});
    endtask

    // One call drives a full cycle: inputs change on the falling edge, checks land 1 time unit after the rising edge.
    task automatic applyStimulus(input logic r, input logic wv, input logic [4:0] wid, input logic [31:0] wdat,
                                 input logic mv, input logic [4:0] mid, input logic [31:0] mdat,
                                 input logic dv, input logic [4:0] did, input logic [31:0] ddat);
        @(negedge clk);
        rst = r;
        wb_reg_write = wv;
        wb_write_id = wid;
        wb_write_data = wdat;
        mdu_valid = mv;
        mdu_write_id = mid;
        mdu_write_data = mdat;
        dbg_valid = dv;
        dbg_write_id = did;
        dbg_write_data = ddat;
        @(posedge clk);
        modelStep();
        #1;
        checkOutput();
    endtask

    task automatic idleCycle();
        applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic wbOnly(input logic [4:0] wid, input logic [31:0] wdat);
        applyStimulus(1'b1, 1'b1, wid, wdat, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    initial begin
        $display("[TB] reset with all valids high");
        applyStimulus(1'b0, 1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22, 1'b1, 5'd5, 32'h33);
        applyStimulus(1'b0, 1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22, 1'b1, 5'd5, 32'h33);
        idleCycle();

        $display("[TB] writeback only");
        wbOnly(5'd3, 32'h0000_0007);
        idleCycle();
        wbOnly(5'd0, 32'h0000_0007);
        idleCycle();

        $display("[TB] MDU in idle slot");
        applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0);
        idleCycle();
        idleCycle();

        $display("[TB] starvation");
        applyStimulus(1'b1, 1'b1, 5'd1, 32'h100, 1'b1, 5'd9, 32'h0BAD_F00D, 1'b0, 5'd0, 32'd0);
        for (int i = 0; i < LIMIT + 2; i++) wbOnly(5'd1, 32'h200 + i);
        idleCycle();
        idleCycle();

        $display("[TB] contention");
        applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 32'h6666, 1'b1, 5'd7, 32'h7777);
        idleCycle();
        idleCycle();
        idleCycle();

        $display("[TB] reset mid-operation");
        applyStimulus(1'b1, 1'b1, 5'd2, 32'h300, 1'b1, 5'd12, 32'hC0C0, 1'b0, 5'd0, 32'd0);
        for (int i = 0; i < LIMIT + 1; i++) wbOnly(5'd2, 32'h400 + i);
        applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        idleCycle();
        idleCycle();

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 63) != 0),
                          ($urandom_range(0, 99) < 55), 5'($urandom_range(0, 31)), $urandom,
                          ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 31)), $urandom,
                          ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 31)), $urandom);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
